// File: rtl/spawn_scheduler.sv
// Enemy spawn scheduler: while the game is in the play scene, the block counts
// frame ticks down from a level-dependent interval. It then picks the next free
// enemy slot round-robin and issues a one-hot spawn request with a pseudo-random
// column. The request is held until the slot accepts it.
//
// Ports:
//   clk, rst_n    - clock, asynchronous active-low reset
//   frame_tick    - one-cycle pulse per video frame
//   scene         - game scene (1 = play); any other value idles the block
//   level         - difficulty level, shortens the spawn interval
//   spawn_ready   - per-slot acceptance of a spawn request
//   slot_done     - per-slot pulse: enemy avoided or destroyed
//   spawn_valid   - one-hot spawn request
//   spawn_X       - spawn column, valid while spawn_valid is non-zero
//   active_mask   - per-slot busy flags
//   wave_count    - accepted spawns since play started, saturating at 255
module spawn_scheduler #(
    parameter int unsigned N_SLOTS       = 4,
    parameter int unsigned BASE_INTERVAL = 120,
    parameter int unsigned MIN_INTERVAL  = 16,
    parameter int unsigned X_MIN         = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               frame_tick,
    input  logic [1:0]         scene,
    input  logic [4:0]         level,
    input  logic [N_SLOTS-1:0] spawn_ready,
    input  logic [N_SLOTS-1:0] slot_done,
    output logic [N_SLOTS-1:0] spawn_valid,
    output logic [8:0]         spawn_X,
    output logic [N_SLOTS-1:0] active_mask,
    output logic [7:0]         wave_count
);

    localparam int unsigned PTR_W  = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1;
    localparam int unsigned CNT_W  = 10;
    localparam int unsigned X_W    = 9;
    localparam int unsigned WAVE_W = 8;
    localparam int unsigned LFSR_W = 16;

    localparam logic [LFSR_W-1:0] LFSR_SEED  = 16'hACE1;
    localparam logic [1:0]        SCENE_PLAY = 2'd1;
    localparam logic [PTR_W-1:0]  PTR_LAST   = PTR_W'(N_SLOTS - 1);
    localparam logic [WAVE_W-1:0] WAVE_MAX   = '1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        PICK  = 2'd2,
        ISSUE = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [PTR_W-1:0]    ptr_q, ptr_d;
    logic [PTR_W-1:0]    slot_q, slot_d;
    logic [LFSR_W-1:0]   lfsr_q, lfsr_d;
    logic [N_SLOTS-1:0]  spawn_valid_q, spawn_valid_d;
    logic [X_W-1:0]      spawn_x_q, spawn_x_d;
    logic [N_SLOTS-1:0]  active_mask_q, active_mask_d;
    logic [WAVE_W-1:0]   wave_q, wave_d;

    logic [CNT_W-1:0]    level_x4;
    logic [CNT_W-1:0]    base_ival;
    logic [CNT_W-1:0]    floor_ival;
    logic [CNT_W-1:0]    diff_ival;
    logic [CNT_W-1:0]    interval;
    logic                pick_found;
    logic [PTR_W-1:0]    pick_idx;
    int unsigned         scan_idx;
    logic                lfsr_fb;

    function automatic logic [N_SLOTS-1:0] slot_onehot(input logic [PTR_W-1:0] idx);
        slot_onehot      = '0;
        slot_onehot[idx] = 1'b1;
    endfunction

    // Reload value: BASE - 4*level, floored at MIN; clamps rather than wrapping below zero.
    always_comb begin
        level_x4   = CNT_W'({level, 2'b00});
        base_ival  = CNT_W'(BASE_INTERVAL);
        floor_ival = CNT_W'(MIN_INTERVAL);
        diff_ival  = (base_ival > level_x4) ? (base_ival - level_x4) : '0;
        interval   = (diff_ival > floor_ival) ? diff_ival : floor_ival;
    end

    // First free slot scanning upward from the round-robin pointer, with wrap.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        scan_idx   = 0;
        for (int unsigned i = 0; i < N_SLOTS; i++) begin
            scan_idx = (32'(ptr_q) + i) % N_SLOTS;
            if (!pick_found && !active_mask_q[PTR_W'(scan_idx)]) begin
                pick_found = 1'b1;
                pick_idx   = PTR_W'(scan_idx);
            end
        end
    end

    // Next-state and output logic.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        ptr_d         = ptr_q;
        slot_d        = slot_q;
        spawn_valid_d = spawn_valid_q;
        spawn_x_d     = spawn_x_q;
        wave_d        = wave_q;

        // Fibonacci LFSR x^16+x^14+x^13+x^11+1 in right-shift form; runs in every state.
        lfsr_fb = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];
        lfsr_d  = {lfsr_fb, lfsr_q[LFSR_W-1:1]};

        // Done pulses on free slots fall out naturally as no-ops.
        active_mask_d = active_mask_q & ~slot_done;

        if (scene != SCENE_PLAY) begin
            state_d       = IDLE;
            spawn_valid_d = '0;
            active_mask_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = WAIT;
                    cnt_d   = interval;
                    wave_d  = '0;
                    ptr_d   = '0;
                end
                WAIT: begin
                    if (frame_tick) begin
                        if (cnt_q == '0) begin
                            state_d = PICK;
                        end else begin
                            cnt_d = cnt_q - CNT_W'(1);
                        end
                    end
                end
                PICK: begin
                    if (pick_found) begin
                        state_d       = ISSUE;
                        slot_d        = pick_idx;
                        spawn_valid_d = slot_onehot(pick_idx);
                        spawn_x_d     = X_W'(X_MIN) + X_W'(lfsr_q[6:0]);
                    end else begin
                        // Counter stays at zero so the next frame tick retries the pick.
                        state_d = WAIT;
                        cnt_d   = '0;
                    end
                end
                ISSUE: begin
                    if (spawn_ready[slot_q]) begin
                        state_d       = WAIT;
                        spawn_valid_d = '0;
                        active_mask_d = active_mask_d | slot_onehot(slot_q);
                        ptr_d         = (slot_q == PTR_LAST) ? '0 : (slot_q + PTR_W'(1));
                        cnt_d         = interval;
                        wave_d        = (wave_q == WAVE_MAX) ? wave_q : (wave_q + WAVE_W'(1));
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            ptr_q         <= '0;
            slot_q        <= '0;
            lfsr_q        <= LFSR_SEED;
            spawn_valid_q <= '0;
            spawn_x_q     <= '0;
            active_mask_q <= '0;
            wave_q        <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            ptr_q         <= ptr_d;
            slot_q        <= slot_d;
            lfsr_q        <= lfsr_d;
            spawn_valid_q <= spawn_valid_d;
            spawn_x_q     <= spawn_x_d;
            active_mask_q <= active_mask_d;
            wave_q        <= wave_d;
        end
    end

    assign spawn_valid = spawn_valid_q;
    assign spawn_X     = spawn_x_q;
    assign active_mask = active_mask_q;
    assign wave_count  = wave_q;

endmodule

// File: tb/tb_spawn_scheduler.sv
// Bench for spawn_scheduler: directed phases with randomized handshake delays,
// ready noise and done pulses, checked against a behavioural model of slots,
// pointer, wave count, interval arithmetic and the spawn-column LFSR.
`timescale 1ns/1ps
module tb_spawn_scheduler;

    localparam int NS   = 4;
    localparam int BASE = 120;
    localparam int MINI = 16;
    localparam int XMIN = 64;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       frame_tick;
    logic [1:0] scene;
    logic [4:0] level;
    logic [3:0] spawn_ready;
    logic [3:0] slot_done;
    logic [3:0] spawn_valid;
    logic [8:0] spawn_X;
    logic [3:0] active_mask;
    logic [7:0] wave_count;

    int errors = 0;
    int checks = 0;

    logic [15:0] m_lfsr;
    logic [15:0] m_lfsr_used;
    logic [3:0]  m_active;
    int          m_ptr;
    int          m_wave;
    int          m_ticks;

    spawn_scheduler #(
        .N_SLOTS      (NS),
        .BASE_INTERVAL(BASE),
        .MIN_INTERVAL (MINI),
        .X_MIN        (XMIN)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .frame_tick (frame_tick),
        .scene      (scene),
        .level      (level),
        .spawn_ready(spawn_ready),
        .slot_done  (slot_done),
        .spawn_valid(spawn_valid),
        .spawn_X    (spawn_X),
        .active_mask(active_mask),
        .wave_count (wave_count)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] lfsr_step(input logic [15:0] x);
        logic [15:0] b;
        b = ((x >> 0) ^ (x >> 2) ^ (x >> 3) ^ (x >> 5)) & 16'h0001;
        return (x >> 1) | (b << 15);
    endfunction

    // Reference LFSR; m_lfsr_used holds the value seen just before the latest edge.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_lfsr      = 16'hACE1;
            m_lfsr_used = 16'hACE1;
        end else begin
            m_lfsr_used = m_lfsr;
            m_lfsr      = lfsr_step(m_lfsr);
        end
    end

    function automatic int interval_of(input int lv);
        int d;
        d = BASE - 4 * lv;
        return (d < MINI) ? MINI : d;
    endfunction

    function automatic int exp_slot();
        for (int k = 0; k < NS; k++) begin
            int s;
            s = (m_ptr + k) % NS;
            if (!m_active[s]) return s;
        end
        return -1;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        @(negedge clk);
    endtask

    // Issue frame ticks until a request appears; n = tick index, 0 if none within max_t.
    task automatic wait_spawn(input int max_t, output int n);
        n = 0;
        for (int t = 1; t <= max_t; t++) begin
            tick();
            if (spawn_valid != 4'b0) begin
                n = t;
                break;
            end
        end
    endtask

    task automatic start_play(input logic [4:0] lv);
        level = lv;
        scene = 2'd1;
        @(negedge clk);
        m_active = '0;
        m_ptr    = 0;
        m_wave   = 0;
        m_ticks  = interval_of(int'(lv)) + 1;
        check("start wave", 32'(wave_count), 32'(0));
    endtask

    // mode 0: handshake, 1: leave play mid-request, 2: async reset mid-request.
    // free_mode 0: keep slot busy, 1: free it, 2: free randomly (never more than two busy).
    task automatic do_spawn(input string tag, input int hold, input int free_mode,
                            input bit allow_done, input int mode);
        int          n;
        int          slot;
        logic [3:0]  oh;
        logic [3:0]  d;
        logic [8:0]  x_exp;
        bit          fr;
        wait_spawn(m_ticks + 5, n);
        check({tag, " ticks"}, 32'(n), 32'(m_ticks));
        if (n == 0) return;
        slot  = exp_slot();
        oh    = (slot < 0) ? 4'b0 : 4'(32'(1) << slot);
        x_exp = 9'(XMIN) + 9'(m_lfsr_used[6:0]);
        check({tag, " valid"}, 32'(spawn_valid), 32'(oh));
        check({tag, " X"}, 32'(spawn_X), 32'(x_exp));
        spawn_ready = 4'($urandom) & ~oh;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({tag, " hold valid"}, 32'(spawn_valid), 32'(oh));
            check({tag, " hold X"}, 32'(spawn_X), 32'(x_exp));
        end
        if (mode == 1) begin
            scene = 2'd2;
            @(negedge clk);
            check({tag, " scene valid"}, 32'(spawn_valid), 32'(0));
            check({tag, " scene mask"}, 32'(active_mask), 32'(0));
            spawn_ready = '0;
            m_active    = '0;
            return;
        end
        if (mode == 2) begin
            #2 rst_n = 1'b0;
            #1;
            check({tag, " rst valid"}, 32'(spawn_valid), 32'(0));
            check({tag, " rst X"}, 32'(spawn_X), 32'(0));
            check({tag, " rst mask"}, 32'(active_mask), 32'(0));
            check({tag, " rst wave"}, 32'(wave_count), 32'(0));
            spawn_ready = '0;
            @(negedge clk);
            rst_n    = 1'b1;
            m_active = '0;
            m_ptr    = 0;
            m_wave   = 0;
            m_ticks  = interval_of(int'(level)) + 1;
            for (int i = 0; i < 10; i++) begin
                @(negedge clk);
                check({tag, " no stale"}, 32'(spawn_valid), 32'(0));
            end
            return;
        end
        d           = allow_done ? (m_active & ~oh & 4'($urandom)) : 4'b0;
        spawn_ready = 4'($urandom) | oh;
        slot_done   = d;
        @(negedge clk);
        spawn_ready = '0;
        slot_done   = '0;
        m_active    = (m_active & ~d) | oh;
        m_ptr       = (slot + 1) % NS;
        if (m_wave < 255) m_wave++;
        m_ticks     = interval_of(int'(level)) + 1;
        check({tag, " post valid"}, 32'(spawn_valid), 32'(0));
        check({tag, " post mask"}, 32'(active_mask), 32'(m_active));
        check({tag, " post wave"}, 32'(wave_count), 32'(m_wave));
        fr = (free_mode == 1) ||
             (free_mode == 2 && ($countones(m_active) >= 2 || $urandom_range(0, 1) == 1));
        if (fr) begin
            slot_done = oh | (4'($urandom) & ~m_active);
            @(negedge clk);
            slot_done = '0;
            m_active  = m_active & ~oh;
            check({tag, " free mask"}, 32'(active_mask), 32'(m_active));
        end
    endtask

    initial begin
        int n;
        rst_n       = 1'b1;
        frame_tick  = 1'b0;
        scene       = 2'd0;
        level       = 5'd0;
        spawn_ready = '0;
        slot_done   = '0;
        m_active    = '0;
        m_ptr       = 0;
        m_wave      = 0;
        m_ticks     = 0;

        // Asynchronous reset before any clock edge.
        #2 rst_n = 1'b0;
        #1;
        check("reset valid", 32'(spawn_valid), 32'(0));
        check("reset X", 32'(spawn_X), 32'(0));
        check("reset mask", 32'(active_mask), 32'(0));
        check("reset wave", 32'(wave_count), 32'(0));
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("idle valid", 32'(spawn_valid), 32'(0));

        // Basic spawn at level 0: 121 ticks, slot 0.
        start_play(5'd0);
        do_spawn("basic", 0, 0, 1'b0, 0);
        check("basic wave", 32'(wave_count), 32'(1));
        check("basic mask", 32'(active_mask), 32'(1));
        slot_done = 4'b1001;
        @(negedge clk);
        slot_done = '0;
        m_active  = '0;
        check("free mask", 32'(active_mask), 32'(0));

        // Round robin; level change only affects later reloads (first stays 121).
        level = 5'd10;
        for (int i = 0; i < 4; i++) do_spawn("rr", int'($urandom_range(0, 3)), 1, 1'b1, 0);

        // Fill every slot at level 31, then verify the stalled pick and its retry.
        level = 5'd31;
        for (int i = 0; i < 4; i++) do_spawn("fill", 0, 0, 1'b0, 0);
        check("full mask", 32'(active_mask), 32'(4'b1111));
        wait_spawn(40, n);
        check("full no spawn", 32'(n), 32'(0));
        check("full valid", 32'(spawn_valid), 32'(0));
        slot_done = 4'b0100;
        @(negedge clk);
        slot_done = '0;
        m_active  = 4'b1011;
        check("done2 mask", 32'(active_mask), 32'(4'b1011));
        m_ticks = 1;
        do_spawn("retry", 1, 0, 1'b0, 0);

        // Held request for 50 cycles, then leave play.
        slot_done = 4'b1111;
        @(negedge clk);
        slot_done = '0;
        m_active  = '0;
        do_spawn("held", 50, 0, 1'b0, 1);

        // Async reset in the middle of an outstanding request.
        start_play(5'd31);
        do_spawn("pre rst", 0, 0, 1'b0, 0);
        do_spawn("rst", 2, 0, 1'b0, 2);
        do_spawn("post rst", 0, 1, 1'b0, 0);

        // Long run to saturate the wave counter.
        for (int i = 0; i < 300; i++) do_spawn("sat", int'($urandom_range(0, 2)), 2, 1'b1, 0);
        check("wave saturated", 32'(wave_count), 32'(255));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/spawn_scheduler.md
SPAWN_SCHEDULER -- requirements
Module: spawn_scheduler

Interface
REQ-001 SHALL have parameter N_SLOTS, default 4, number of enemy slots scheduled.
REQ-002 SHALL have parameter BASE_INTERVAL, default 120, frames between spawns at level 0.
REQ-003 SHALL have parameter MIN_INTERVAL, default 16, floor on the spawn interval in frames.
REQ-004 SHALL have parameter X_MIN, default 64, leftmost spawn column in pixels.
REQ-005 SHALL have port clk, input, 1, system clock; the only clock.
REQ-006 SHALL have port rst_n, input, 1, reset, asynchronous, active-low.
REQ-007 SHALL have port frame_tick, input, 1, one-cycle pulse per video frame (60 Hz).
REQ-008 SHALL have port scene, input, 2, game scene; value 1 = play.
REQ-009 SHALL have port level, input, 5, current difficulty level.
REQ-010 SHALL have port spawn_ready, input, N_SLOTS, per-slot acceptance of a spawn.
REQ-011 SHALL have port slot_done, input, N_SLOTS, per-slot one-cycle pulse: enemy avoided or destroyed.
REQ-012 SHALL have port spawn_valid, output, N_SLOTS, one-hot spawn request.
REQ-013 SHALL have port spawn_X, output, 9, spawn column; valid while any spawn_valid bit is high.
REQ-014 SHALL have port active_mask, output, N_SLOTS, busy flag per slot.
REQ-015 SHALL have port wave_count, output, 8, total accepted spawns since play started.

Function
REQ-016 SHALL implement states IDLE, WAIT, PICK, ISSUE.
REQ-017 In any state, scene!=1 SHALL force IDLE on the next clock, deassert spawn_valid and clear active_mask.
REQ-018 IDLE with scene==1 SHALL go to WAIT; on this transition it loads the interval counter, clears wave_count and sets the round-robin pointer to 0.
REQ-019 Interval SHALL be max(BASE_INTERVAL - 4*level, MIN_INTERVAL), computed in 10-bit unsigned arithmetic with no wrap below zero.
REQ-020 WAIT SHALL decrement the interval counter only on frame_tick; WAIT SHALL go to PICK on the frame_tick when the counter is at 0.
REQ-021 PICK SHALL select, within one cycle, the first free slot (active_mask bit 0), scanning upward from the round-robin pointer and wrapping modulo N_SLOTS.
REQ-022 PICK with no free slot SHALL return to WAIT with the counter held at 0, so the pick is retried on the next frame_tick.
REQ-023 PICK with a free slot SHALL go to ISSUE and latch spawn_X.
REQ-024 ISSUE SHALL hold exactly one spawn_valid bit high, and spawn_X constant, until the matching spawn_ready bit is sampled high.
REQ-025 On the ISSUE handshake cycle the block SHALL, at the next edge: set that slot's active_mask bit, deassert spawn_valid, and set the pointer to slot+1 mod N_SLOTS.
REQ-026 On the same handshake edge the block SHALL reload the interval, increment wave_count saturating at 255, and go to WAIT.
REQ-027 spawn_ready bits for non-requested slots SHALL be ignored.
REQ-028 An LFSR (16 bit, taps 16,14,13,11, seed 0xACE1) SHALL advance every clock, including in IDLE.
REQ-029 spawn_X SHALL be X_MIN + lfsr[6:0], giving a range of X_MIN..X_MIN+127, latched on PICK->ISSUE.
REQ-030 slot_done on a busy slot SHALL clear its active_mask bit at the next edge; slot_done on a free slot SHALL be ignored.
REQ-031 slot_done and a handshake on different slots in the same cycle SHALL both take effect.
REQ-032 Changes to level SHALL only affect the next interval reload, never a running countdown.

Reset
REQ-033 rst_n low SHALL immediately force state=IDLE, spawn_valid=0, active_mask=0, wave_count=0, spawn_X=0, pointer=0, counter=0, lfsr=0xACE1, independent of clk.
REQ-034 Reset deasserted mid-ISSUE SHALL resume from IDLE; no stale request is re-issued.

Verification
REQ-035 Bench SHALL cover basic spawn: scene=1, level=0, ready tied high -> first spawn_valid=0001 after 121 frame_ticks; wave_count=1; active_mask=0001.
REQ-036 Bench SHALL cover round-robin: all four slots freed after each spawn -> slot order 0,1,2,3,0.
REQ-037 Bench SHALL cover level/interval floor: level=31 -> interval 16 frames; level=10 -> interval 80 frames.
REQ-038 Bench SHALL cover all slots busy: active_mask=1111 -> no spawn_valid. Then a slot_done pulse on slot 2 -> spawn_valid=0100 on the next frame_tick+1 cycle.
REQ-039 Bench SHALL cover the held handshake: spawn_ready low for 50 cycles -> spawn_valid and spawn_X stable throughout. Then scene changes to 2 -> spawn_valid=0 and active_mask=0 on the next edge.
REQ-040 Bench SHALL cover async reset mid-ISSUE: all outputs are at reset values with no clock edge; wave_count saturates at 255 after 300 spawns.
